// File: rtl/lsu_axi_pkg.sv
// Shared types for the LSU-to-AXI4-Lite bridge: FSM states, AXI response codes, size codes.
// Pure declarations, no logic, no latency, no flow control.
package lsu_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        AXI_OKAY   = 2'b00,
        AXI_EXOKAY = 2'b01,
        AXI_SLVERR = 2'b10,
        AXI_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } lsu_size_e;

    function automatic logic [2:0] axi_size(input logic [1:0] lsu_size);
        return {1'b0, lsu_size};
    endfunction

    // Anything other than OKAY is reported to the core as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_OKAY;
    endfunction

endpackage

// File: rtl/lsu_axi_timeout.sv
// Wait-cycle counter for the bridge: counts while run_i, zeroes on clear_i, flags expired_o at LIMIT.
// expired_o is a compare on the registered count; no flow control of its own.
module lsu_axi_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic run_i,
    input  logic clear_i,
    output logic expired_o
);
    localparam int CW = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run_i || clear_i) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/lsu_axi_bridge.sv
// Single-outstanding LSU request to AXI4-Lite bridge; zero-wait latency accept->respValid is 3 cycles.
// Waits on AXI ready/valid indefinitely (bounded by TIMEOUT_CYCLES when LSU_AXI_TIMEOUT_EN is defined).
module lsu_axi_bridge
    import lsu_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef LSU_AXI_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                lsu_reqValid,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [1:0]          lsu_size,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_respValid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_err,
    output logic [ADDR_W-1:0]   araddr,
    output logic [2:0]          arsize,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [2:0]          awsize,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wmask_q, wmask_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                aw_fire, w_fire;

`ifdef LSU_AXI_TIMEOUT_EN
    logic tmo_run, tmo_clear, tmo_expired;

    assign tmo_run   = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT) ||
                       (state_q == ST_WR_REQ) || (state_q == ST_WR_WAIT);
    assign tmo_clear = (state_d != state_q);

    lsu_axi_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .run_i    (tmo_run),
        .clear_i  (tmo_clear),
        .expired_o(tmo_expired)
    );
`endif

    // The load/store direction is carried by the RD_*/WR_* state itself.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        aw_fire   = 1'b0;
        w_fire    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (lsu_reqValid) begin
                    addr_d    = lsu_addr;
                    size_d    = lsu_size;
                    wdata_d   = lsu_wdata;
                    wmask_d   = lsu_wmask;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = lsu_wen ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                rready = 1'b1;
                if (rvalid) begin
                    rdata_d = rdata;
                    err_d   = resp_is_err(rresp);
                    state_d = ST_RESP;
                end
            end
            ST_WR_REQ: begin
                // AW and W complete independently; leave once both have fired.
                awvalid   = !aw_done_q;
                wvalid    = !w_done_q;
                aw_fire   = awvalid && awready;
                w_fire    = wvalid && wready;
                aw_done_d = aw_done_q || aw_fire;
                w_done_d  = w_done_q || w_fire;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WR_WAIT;
                end
            end
            ST_WR_WAIT: begin
                bready = 1'b1;
                if (bvalid) begin
                    rdata_d = '0;
                    err_d   = resp_is_err(bresp);
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef LSU_AXI_TIMEOUT_EN
        if (tmo_expired) begin
            arvalid = 1'b0;
            rready  = 1'b0;
            awvalid = 1'b0;
            wvalid  = 1'b0;
            bready  = 1'b0;
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign araddr        = addr_q;
    assign arsize        = axi_size(size_q);
    assign awaddr        = addr_q;
    assign awsize        = axi_size(size_q);
    assign wdata         = wdata_q;
    assign wstrb         = wmask_q;
    assign lsu_respValid = (state_q == ST_RESP);
    assign lsu_rdata     = rdata_q;
    assign lsu_err       = err_q;

endmodule

// File: tb/tb_lsu_axi_bridge.sv
// Scoreboarded bench for lsu_axi_bridge: directed cases plus randomized loads/stores against a slave model.
// Define LSU_AXI_TIMEOUT_EN to also exercise the timeout path with TIMEOUT_CYCLES=8.
module tb_lsu_axi_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic        lsu_reqValid;
    logic [31:0] lsu_addr;
    logic [1:0]  lsu_size;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    always #5 clock = ~clock;

    lsu_axi_bridge #(
        .ADDR_W(32),
        .DATA_W(32)
`ifdef LSU_AXI_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clock(clock), .reset(reset),
        .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Expected core responses, oldest first.
    logic [31:0] sb_dat[$];
    logic        sb_err[$];

    // Request currently in flight, as the slave should see it.
    logic [31:0] cur_addr  = '0;
    logic [1:0]  cur_size  = '0;
    logic [31:0] cur_wdata = '0;
    logic [3:0]  cur_wmask = '0;
    bit          allow_drop = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: pops the scoreboard on every completion and polices AXI channel rules.
    bit          ar_pend = 0, aw_pend = 0, w_pend = 0;
    logic [31:0] ar_prev, aw_prev, w_prev;
    always @(negedge clock) begin
        if (lsu_respValid) begin
            if (sb_dat.size() == 0) begin
                chk("unexpected_resp", 64'(lsu_respValid), 64'd0);
            end else begin
                chk("lsu_rdata", 64'(lsu_rdata), 64'(sb_dat.pop_front()));
                chk("lsu_err", 64'(lsu_err), 64'(sb_err.pop_front()));
            end
        end
        if (arvalid && arready) begin
            chk("araddr", 64'(araddr), 64'(cur_addr));
            chk("arsize", 64'(arsize), 64'({1'b0, cur_size}));
        end
        if (awvalid && awready) begin
            chk("awaddr", 64'(awaddr), 64'(cur_addr));
            chk("awsize", 64'(awsize), 64'({1'b0, cur_size}));
        end
        if (wvalid && wready) begin
            chk("wdata", 64'(wdata), 64'(cur_wdata));
            chk("wstrb", 64'(wstrb), 64'(cur_wmask));
        end
        if (!allow_drop && !reset) begin
            if (ar_pend) chk("ar_stable", {31'd0, arvalid, araddr}, {31'd0, 1'b1, ar_prev});
            if (aw_pend) chk("aw_stable", {31'd0, awvalid, awaddr}, {31'd0, 1'b1, aw_prev});
            if (w_pend)  chk("w_stable",  {31'd0, wvalid, wdata},   {31'd0, 1'b1, w_prev});
        end
        ar_pend = !reset && arvalid && !arready;
        aw_pend = !reset && awvalid && !awready;
        w_pend  = !reset && wvalid && !wready;
        ar_prev = araddr;
        aw_prev = awaddr;
        w_prev  = wdata;
    end

    task automatic issue(input bit wen, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] wd, input logic [3:0] wm);
        cur_addr = a; cur_size = sz; cur_wdata = wd; cur_wmask = wm;
        lsu_reqValid = 1'b1; lsu_wen = wen; lsu_addr = a; lsu_size = sz;
        lsu_wdata = wd; lsu_wmask = wm;
        step();
        // Scramble inputs so that only the latched copy can be correct.
        lsu_reqValid = 1'b0; lsu_addr = $urandom; lsu_size = 2'($urandom);
        lsu_wdata = $urandom; lsu_wmask = 4'($urandom); lsu_wen = 1'($urandom);
    endtask

    task automatic finish_resp();
        @(negedge clock);
        chk("resp_latency", 64'(lsu_respValid), 64'd1);
        step();
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] rd,
                           input logic [1:0] rs, input int ar_dly, input int r_dly, input bit stray);
        int c;
        bit hs;
        sb_dat.push_back(rd);
        sb_err.push_back(rs != 2'b00);
        issue(1'b0, a, sz, 32'($urandom), 4'($urandom));
        bvalid = stray; bresp = 2'b11;
        for (c = 0; c < 100; c++) begin
            arready = (c >= ar_dly);
            @(negedge clock);
            hs = arvalid && arready;
            step();
            if (hs) break;
        end
        arready = 1'b0; bvalid = 1'b0;
        chk("ar_hs_cycle", 64'(c), 64'(ar_dly));
        rdata = rd; rresp = rs;
        for (c = 0; c < 100; c++) begin
            rvalid = (c >= r_dly);
            @(negedge clock);
            hs = rvalid && rready;
            step();
            if (hs) break;
        end
        rvalid = 1'b0; rdata = $urandom;
        chk("r_hs_cycle", 64'(c), 64'(r_dly));
        finish_resp();
    endtask

    task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                            input logic [3:0] wm, input logic [1:0] bs, input int aw_dly,
                            input int w_dly, input int b_dly, input bit stray);
        int c;
        int aw_c;
        int w_c;
        bit hs;
        sb_dat.push_back(32'd0);
        sb_err.push_back(bs != 2'b00);
        issue(1'b1, a, sz, wd, wm);
        aw_c = -1; w_c = -1;
        rvalid = stray; rresp = 2'b10; rdata = $urandom;
        for (c = 0; c < 100; c++) begin
            awready = (c >= aw_dly);
            wready  = (c >= w_dly);
            @(negedge clock);
            if (aw_c >= 0) chk("awvalid_drop", 64'(awvalid), 64'd0);
            if (w_c >= 0)  chk("wvalid_drop", 64'(wvalid), 64'd0);
            if (awvalid && awready && aw_c < 0) aw_c = c;
            if (wvalid && wready && w_c < 0) w_c = c;
            step();
            if (aw_c >= 0 && w_c >= 0) break;
        end
        awready = 1'b0; wready = 1'b0; rvalid = 1'b0;
        chk("aw_hs_cycle", 64'(aw_c), 64'(aw_dly));
        chk("w_hs_cycle", 64'(w_c), 64'(w_dly));
        bresp = bs;
        for (c = 0; c < 100; c++) begin
            bvalid = (c >= b_dly);
            @(negedge clock);
            hs = bvalid && bready;
            step();
            if (hs) break;
        end
        bvalid = 1'b0;
        chk("b_hs_cycle", 64'(c), 64'(b_dly));
        finish_resp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] a, d;
        logic [1:0]  sz, rs;
        logic [3:0]  wm;
        reset = 1'b1; lsu_reqValid = 1'b0; lsu_addr = '0; lsu_size = '0; lsu_wen = 1'b0;
        lsu_wdata = '0; lsu_wmask = '0; arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
        repeat (3) step();
        @(negedge clock);
        chk("rst_ctrl", 64'({arvalid, rready, awvalid, wvalid, bready, lsu_respValid, lsu_err}), 64'd0);
        chk("rst_data", {lsu_rdata, araddr}, 64'd0);
        chk("rst_wstrb", 64'({wstrb, wdata}), 64'd0);
        step();
        reset = 1'b0;

        do_load(32'h8000_0004, 2'b10, 32'hDEAD_BEEF, 2'b00, 0, 0, 1'b0);
        do_store(32'h8000_0010, 2'b10, 32'h0000_AB00, 4'b0010, 2'b00, 0, 3, 1, 1'b0);
        do_load(32'h8000_0020, 2'b01, 32'h0BAD_F00D, 2'b10, 5, 0, 1'b1);

        // Request held high against an always-ready slave: one accept every 4 cycles.
        cur_addr = 32'h8000_0100; cur_size = 2'b10;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
        repeat (5) begin
            sb_dat.push_back(32'h1234_5678);
            sb_err.push_back(1'b0);
        end
        lsu_reqValid = 1'b1; lsu_wen = 1'b0; lsu_addr = cur_addr; lsu_size = cur_size;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            chk("b2b_resp", 64'(lsu_respValid), 64'((k % 4) == 3));
            step();
        end
        lsu_reqValid = 1'b0; arready = 1'b0; rvalid = 1'b0;
        @(negedge clock);
        chk("b2b_tail", 64'(lsu_respValid), 64'd0);
        step();

        // Reset while waiting for R: outputs drop next cycle and no completion follows.
        issue(1'b0, 32'h8000_0200, 2'b10, 32'd0, 4'd0);
        arready = 1'b1;
        @(negedge clock);
        step();
        arready = 1'b0;
        @(negedge clock);
        chk("rdwait_rready", 64'(rready), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_ctrl", 64'({arvalid, rready, awvalid, wvalid, bready, lsu_respValid}), 64'd0);
        chk("mid_rst_data", 64'({lsu_err, lsu_rdata}), 64'd0);
        rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
        step();
        @(negedge clock);
        chk("mid_rst_nores", 64'({rready, lsu_respValid}), 64'd0);
        step();
        rvalid = 1'b0;

        for (int n = 0; n < 40; n++) begin
            a = $urandom; d = $urandom; sz = 2'($urandom); rs = 2'($urandom); wm = 4'($urandom);
            if ($urandom_range(0, 1) == 1)
                do_store(a, sz, d, wm, rs, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), 1'($urandom));
            else
                do_load(a, sz, d, rs, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end

`ifdef LSU_AXI_TIMEOUT_EN
        // Slave never answers AR: forced error completion 9 cycles after entering RD_REQ.
        sb_dat.push_back(32'd0);
        sb_err.push_back(1'b1);
        allow_drop = 1'b1;
        issue(1'b0, 32'h8000_0300, 2'b10, 32'd0, 4'd0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            chk("tmo_resp", 64'(lsu_respValid), 64'(k == 10));
            chk("tmo_arvalid", 64'(arvalid), 64'(k < 10));
            step();
        end
        allow_drop = 1'b0;
`endif

        repeat (2) step();
        chk("sb_drained", 64'(sb_dat.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
